// File: rtl/dnn_pkg.sv
// Shared types and elaboration helpers for the DNN parameter loader.
package dnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } ld_state_t;

    function automatic int num_groups(input int f_num, input int lanes);
        return f_num / lanes;
    endfunction

    function automatic int grp_width(input int groups);
        return (groups > 1) ? $clog2(groups) : 1;
    endfunction

    function automatic bit lanes_ok(input int f_num, input int lanes);
        return (lanes > 0) && (f_num >= lanes) && ((f_num % lanes) == 0);
    endfunction

endpackage

// File: rtl/dnn_param_loader.sv
// Streams weight/bias words into F_NUM cores, LANES cores per group,
// with stream-length checking and done/error status.
module dnn_param_loader
    import dnn_pkg::*;
#(
    parameter int F_NUM = 16,
    parameter int LANES = 4,
    parameter int DW    = 16,
    parameter int AW    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  bias_mode,
    input  logic [AW-1:0]         ks,
    input  logic                  src_valid,
    input  logic [LANES*DW-1:0]   src_data,
    input  logic                  src_last,
    output logic                  src_ready,
    output logic [F_NUM-1:0]      wr_en,
    output logic                  wr_bias,
    output logic [AW-1:0]         wr_addr,
    output logic [LANES*DW-1:0]   wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err_len
);

    localparam int G  = num_groups(F_NUM, LANES);
    localparam int GW = grp_width(G);

    if (!lanes_ok(F_NUM, LANES)) begin : g_bad_lanes
        $error("F_NUM must be a non-zero multiple of LANES");
    end

    ld_state_t     state;
    logic          mode_bias;
    logic [AW-1:0] len_m1;
    logic [AW-1:0] addr;
    logic [GW-1:0] grp;
    logic          hs;
    logic          last_beat;

    function automatic logic [F_NUM-1:0] grp_mask(input logic [GW-1:0] g);
        logic [F_NUM-1:0] m;
        m = '0;
        for (int i = 0; i < F_NUM; i++) begin
            m[i] = ((i / LANES) == int'(g));
        end
        return m;
    endfunction

    assign hs        = src_valid & src_ready;
    assign last_beat = (grp == GW'(G - 1)) && (addr == len_m1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode_bias <= 1'b0;
            len_m1    <= '0;
            addr      <= '0;
            grp       <= '0;
            src_ready <= 1'b0;
            wr_en     <= '0;
            wr_bias   <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            wr_en <= '0;
            done  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_bias <= bias_mode;
                        len_m1    <= bias_mode ? '0 : ks - AW'(1);
                        addr      <= '0;
                        grp       <= '0;
                        err_len   <= 1'b0;
                        busy      <= 1'b1;
                        // A zero-length weight load is an immediate error.
                        if (!bias_mode && ks == '0) begin
                            err_len <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            src_ready <= 1'b1;
                            state     <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (hs) begin
                        wr_en   <= grp_mask(grp);
                        wr_addr <= mode_bias ? '0 : addr;
                        wr_data <= src_data;
                        wr_bias <= mode_bias;
                        if (last_beat) begin
                            if (src_last) begin
                                src_ready <= 1'b0;
                                state     <= ST_DONE;
                            end else begin
                                state <= ST_DRAIN;
                            end
                        end else if (src_last) begin
                            err_len   <= 1'b1;
                            src_ready <= 1'b0;
                            state     <= ST_DONE;
                        end else if (addr == len_m1) begin
                            addr <= '0;
                            grp  <= grp + GW'(1);
                        end else begin
                            addr <= addr + AW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (hs && src_last) begin
                        err_len   <= 1'b1;
                        src_ready <= 1'b0;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    src_ready <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
